// File: rtl/sram_arbiter.sv
// Round-robin arbiter between a fetch port and a data port in front of a single-port SRAM.
// One request in flight; each access runs IDLE -> ACCESS -> WAIT -> RESP.
module sram_arbiter #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    localparam int BE_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_WIDTH-1:0] if_req_addr,
    output logic                  if_rsp_valid,
    input  logic                  if_rsp_ready,
    output logic [DATA_WIDTH-1:0] if_rsp_rdata,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic                  d_req_we,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [BE_WIDTH-1:0]   d_req_be,
    input  logic [DATA_WIDTH-1:0] d_req_wdata,
    output logic                  d_rsp_valid,
    input  logic                  d_rsp_ready,
    output logic [DATA_WIDTH-1:0] d_rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr_sel,
    output logic [BE_WIDTH-1:0]   sram_byte_sel,
    output logic                  sram_read_enable,
    output logic                  sram_write_enable,
    output logic [DATA_WIDTH-1:0] sram_datain,
    input  logic [DATA_WIDTH-1:0] sram_dataout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state, state_next;
    logic                  last_grant;   // 1 = data port won last
    logic                  owner;        // 1 = data port owns the access in flight
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [BE_WIDTH-1:0]   req_be;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  pick_data;
    logic                  idle_open;
    logic                  accept;
    logic                  rsp_hs;

    assign idle_open = (state == IDLE) && !reset;
    assign pick_data = d_req_valid && (!if_req_valid || !last_grant);
    assign accept    = idle_open && (if_req_valid || d_req_valid);
    assign rsp_hs    = owner ? d_rsp_ready : if_rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS:  state_next = WAIT;
            WAIT:    state_next = RESP;
            RESP:    if (rsp_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        if_req_ready      = idle_open && if_req_valid && !pick_data;
        d_req_ready       = idle_open && pick_data;
        if_rsp_valid      = 1'b0;
        if_rsp_rdata      = '0;
        d_rsp_valid       = 1'b0;
        d_rsp_rdata       = '0;
        sram_addr_sel     = '0;
        sram_byte_sel     = '0;
        sram_read_enable  = 1'b0;
        sram_write_enable = 1'b0;
        sram_datain       = '0;
        case (state)
            ACCESS: begin
                sram_addr_sel     = req_addr;
                sram_read_enable  = !req_we;
                sram_write_enable = req_we;
                sram_byte_sel     = req_we ? req_be : '1;
                sram_datain       = req_we ? req_wdata : '0;
            end
            RESP: begin
                if (owner) begin
                    d_rsp_valid = 1'b1;
                    d_rsp_rdata = rsp_data;
                end else begin
                    if_rsp_valid = 1'b1;
                    if_rsp_rdata = rsp_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_be     <= '0;
            req_wdata  <= '0;
            rsp_data   <= '0;
        end else begin
            if (accept) begin
                last_grant <= pick_data;
                owner      <= pick_data;
                req_we     <= pick_data && d_req_we;
                req_addr   <= pick_data ? d_req_addr : if_req_addr;
                req_be     <= pick_data ? d_req_be : '0;
                req_wdata  <= pick_data ? d_req_wdata : '0;
            end
            // Write acks carry zero data; reads capture the SRAM output one cycle after ACCESS.
            if (state == WAIT) begin
                rsp_data <= req_we ? '0 : sram_dataout;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req_valid = 1'b0, if_req_ready;
    logic [6:0]  if_req_addr = '0;
    logic        if_rsp_valid, if_rsp_ready = 1'b1;
    logic [31:0] if_rsp_rdata;
    logic        d_req_valid = 1'b0, d_req_ready, d_req_we = 1'b0;
    logic [6:0]  d_req_addr = '0;
    logic [3:0]  d_req_be = '0;
    logic [31:0] d_req_wdata = '0;
    logic        d_rsp_valid, d_rsp_ready = 1'b1;
    logic [31:0] d_rsp_rdata;
    logic [6:0]  sram_addr_sel;
    logic [3:0]  sram_byte_sel;
    logic        sram_read_enable, sram_write_enable;
    logic [31:0] sram_datain;
    logic [31:0] sram_dataout = '0;

    sram_arbiter #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_rdata(if_rsp_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_addr(d_req_addr), .d_req_be(d_req_be), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata),
        .sram_addr_sel(sram_addr_sel), .sram_byte_sel(sram_byte_sel),
        .sram_read_enable(sram_read_enable), .sram_write_enable(sram_write_enable),
        .sram_datain(sram_datain), .sram_dataout(sram_dataout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout t=%0t", nm, $time);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // SRAM macro: registered read, byte-masked write.
    logic [31:0] sram_mem [128];
    always @(posedge clk) begin
        if (sram_write_enable)
            sram_mem[sram_addr_sel] <= merge(sram_mem[sram_addr_sel], sram_datain, sram_byte_sel);
        if (sram_read_enable)
            sram_dataout <= sram_mem[sram_addr_sel];
    end

    // Reference model: a transaction is accepted, then its ACCESS is 1 cycle later and
    // its response appears 3 cycles after acceptance and holds until taken.
    logic [31:0] ref_mem [128];
    bit          mon_en = 0;
    bit          m_busy = 0;
    int          m_cyc = 0;
    bit          m_owner = 0, m_we = 0, m_last = 1;
    logic [6:0]  m_addr = '0;
    logic [3:0]  m_be = '0;
    logic [31:0] m_wdata = '0, m_rdata = '0;
    bit          if_hs_q = 0, d_hs_q = 0;
    int          grant_log[$];
    logic [31:0] if_rsp_log[$];
    logic [31:0] d_rsp_log[$];
    int          we_cycles = 0;
    int          if_rsp_cnt = 0;

    always @(negedge clk) begin : mon
        logic e_if, e_d, acc, resp;
        if (mon_en) begin
            e_if = !reset && !m_busy && if_req_valid && (!d_req_valid || m_last);
            e_d  = !reset && !m_busy && d_req_valid && (!if_req_valid || !m_last);
            acc  = m_busy && (m_cyc == 1);
            resp = m_busy && (m_cyc == 3);
            chk("if_req_ready", if_req_ready, e_if);
            chk("d_req_ready", d_req_ready, e_d);
            chk("sram_read_enable", sram_read_enable, acc && !m_we);
            chk("sram_write_enable", sram_write_enable, acc && m_we);
            chk("sram_addr_sel", sram_addr_sel, acc ? m_addr : 7'd0);
            chk("sram_byte_sel", sram_byte_sel, acc ? (m_we ? m_be : 4'hF) : 4'h0);
            chk("sram_datain", sram_datain, (acc && m_we) ? m_wdata : 32'd0);
            chk("if_rsp_valid", if_rsp_valid, resp && !m_owner);
            chk("d_rsp_valid", d_rsp_valid, resp && m_owner);
            if (resp && !m_owner) chk("if_rsp_rdata", if_rsp_rdata, m_rdata);
            if (resp && m_owner) chk("d_rsp_rdata", d_rsp_rdata, m_rdata);

            if_hs_q = if_req_valid && if_req_ready;
            d_hs_q  = d_req_valid && d_req_ready;
            if (if_hs_q) grant_log.push_back(0);
            if (d_hs_q) grant_log.push_back(1);
            if (if_rsp_valid && if_rsp_ready) if_rsp_log.push_back(if_rsp_rdata);
            if (d_rsp_valid && d_rsp_ready) d_rsp_log.push_back(d_rsp_rdata);
            if (sram_write_enable) we_cycles++;
            if (if_rsp_valid) if_rsp_cnt++;

            if (reset) begin
                m_busy = 0;
                m_last = 1;
            end else if (!m_busy) begin
                if (e_if) begin
                    m_busy = 1; m_cyc = 1; m_owner = 0; m_we = 0; m_last = 0;
                    m_addr = if_req_addr; m_rdata = ref_mem[if_req_addr];
                end else if (e_d) begin
                    m_busy = 1; m_cyc = 1; m_owner = 1; m_we = d_req_we; m_last = 1;
                    m_addr = d_req_addr; m_be = d_req_be; m_wdata = d_req_wdata;
                    if (d_req_we) begin
                        ref_mem[d_req_addr] = merge(ref_mem[d_req_addr], d_req_wdata, d_req_be);
                        m_rdata = '0;
                    end else begin
                        m_rdata = ref_mem[d_req_addr];
                    end
                end
            end else if (m_cyc == 3) begin
                if (m_owner ? d_rsp_ready : if_rsp_ready) m_busy = 0;
            end else begin
                m_cyc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic data_txn(input bit we, input logic [6:0] a, input logic [3:0] be,
                            input logic [31:0] wd, output logic [31:0] rd);
        bit done;
        d_req_valid = 1; d_req_we = we; d_req_addr = a; d_req_be = be; d_req_wdata = wd;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (d_req_ready) done = 1;
        end
        if (!done) timeout("d_req_accept");
        tick();
        d_req_valid = 0;
        done = 0;
        rd = '0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (d_rsp_valid && d_rsp_ready) begin
                done = 1;
                rd = d_rsp_rdata;
            end
        end
        if (!done) timeout("d_rsp");
        tick();
    endtask

    task automatic fetch_txn(input logic [6:0] a, output logic [31:0] rd);
        bit done;
        if_req_valid = 1; if_req_addr = a;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (if_req_ready) done = 1;
        end
        if (!done) timeout("if_req_accept");
        tick();
        if_req_valid = 0;
        done = 0;
        rd = '0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (if_rsp_valid && if_rsp_ready) begin
                done = 1;
                rd = if_rsp_rdata;
            end
        end
        if (!done) timeout("if_rsp");
        tick();
    endtask

    task automatic do_reset_and_check();
        reset = 1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_if_req_ready", if_req_ready, 0);
        chk("rst_d_req_ready", d_req_ready, 0);
        chk("rst_if_rsp_valid", if_rsp_valid, 0);
        chk("rst_d_rsp_valid", d_rsp_valid, 0);
        chk("rst_sram_en", {sram_read_enable, sram_write_enable}, 0);
        chk("rst_sram_bus", {sram_addr_sel, sram_byte_sel, sram_datain}, 0);
        chk("rst_rdata", {if_rsp_rdata, d_rsp_rdata}, 0);
        tick();
        reset = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit done;
        for (int i = 0; i < 128; i++) begin
            sram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        reset = 1;
        tick();
        mon_en = 1;
        do_reset_and_check();

        // Preload fairness data through the data port.
        data_txn(1, 7'd5, 4'hF, 32'hA5A5A5A5, rd);
        chk("wr_ack_rdata", rd, 32'h0);
        data_txn(1, 7'd7, 4'hF, 32'h5A5A5A5A, rd);

        // Round-robin after a fresh reset: fetch wins the first tie.
        do_reset_and_check();
        grant_log.delete(); if_rsp_log.delete(); d_rsp_log.delete();
        if_req_valid = 1; if_req_addr = 7'd5;
        d_req_valid = 1; d_req_we = 0; d_req_addr = 7'd7;
        @(negedge clk);
        chk("first_tie_if_ready", if_req_ready, 1);
        chk("first_tie_d_ready", d_req_ready, 0);
        for (int i = 0; i < 40 && grant_log.size() < 4; i++) tick();
        if_req_valid = 0; d_req_valid = 0;
        for (int i = 0; i < 40 && (if_rsp_log.size() < 2 || d_rsp_log.size() < 2); i++) tick();
        chk("rr_grants", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size() && i < 4; i++) chk("rr_order", grant_log[i], i % 2);
        chk("rr_if_rsps", if_rsp_log.size(), 2);
        chk("rr_d_rsps", d_rsp_log.size(), 2);
        foreach (if_rsp_log[i]) chk("rr_if_data", if_rsp_log[i], 32'hA5A5A5A5);
        foreach (d_rsp_log[i]) chk("rr_d_data", d_rsp_log[i], 32'h5A5A5A5A);

        // Full-word write then fetch read; one write-enable cycle.
        we_cycles = 0;
        data_txn(1, 7'd10, 4'hF, 32'hDEADBEEF, rd);
        chk("we_one_cycle", we_cycles, 1);
        fetch_txn(7'd10, rd);
        chk("fetch_after_write", rd, 32'hDEADBEEF);

        // Byte-enable writes.
        data_txn(1, 7'd10, 4'b0011, 32'h12345678, rd);
        data_txn(0, 7'd10, 4'h0, 32'h0, rd);
        chk("be_merge_read", rd, 32'hDEAD5678);
        data_txn(1, 7'd10, 4'b0000, 32'hFFFFFFFF, rd);
        chk("be0_ack_rdata", rd, 32'h0);
        data_txn(0, 7'd10, 4'h0, 32'h0, rd);
        chk("be0_unchanged", rd, 32'hDEAD5678);

        // Response back-pressure on the data port with fetch pending.
        d_rsp_ready = 0;
        d_req_valid = 1; d_req_we = 0; d_req_addr = 7'd7;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (d_req_ready) done = 1;
        end
        if (!done) timeout("bp_accept");
        tick();
        d_req_valid = 0;
        if_req_valid = 1; if_req_addr = 7'd5;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (d_rsp_valid) done = 1;
        end
        if (!done) timeout("bp_rsp");
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_d_rsp_valid", d_rsp_valid, 1);
            chk("bp_d_rsp_rdata", d_rsp_rdata, 32'h5A5A5A5A);
            chk("bp_if_req_ready", if_req_ready, 0);
        end
        tick();
        d_rsp_ready = 1;
        @(negedge clk);
        chk("bp_hs_if_req_ready", if_req_ready, 0);
        tick();
        @(negedge clk);
        chk("bp_fetch_granted", if_req_ready, 1);
        tick();
        if_req_valid = 0;
        if_rsp_log.delete();
        for (int i = 0; i < 20 && if_rsp_log.size() == 0; i++) tick();
        chk("bp_fetch_rsps", if_rsp_log.size(), 1);
        if (if_rsp_log.size() > 0) chk("bp_fetch_data", if_rsp_log[0], 32'hA5A5A5A5);

        // Reset during WAIT of a fetch read discards its response.
        if_req_valid = 1; if_req_addr = 7'd5;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (if_req_ready) done = 1;
        end
        if (!done) timeout("mid_rst_accept");
        tick();
        if_req_valid = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        if_rsp_cnt = 0;
        repeat (6) tick();
        chk("mid_rst_no_rsp", if_rsp_cnt, 0);
        fetch_txn(7'd10, rd);
        chk("mid_rst_next_fetch", rd, 32'hDEAD5678);

        // Randomized traffic.
        if_rsp_log.delete(); d_rsp_log.delete();
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset = ($urandom_range(0, 249) == 0);
            if (!if_req_valid || if_hs_q) begin
                if_req_valid = ($urandom_range(0, 2) != 0);
                if_req_addr  = 7'($urandom_range(0, 15));
            end
            if (!d_req_valid || d_hs_q) begin
                d_req_valid = ($urandom_range(0, 2) != 0);
                d_req_we    = 1'($urandom_range(0, 1));
                d_req_addr  = 7'($urandom_range(0, 15));
                d_req_be    = 4'($urandom_range(0, 15));
                d_req_wdata = $urandom;
            end
            if_rsp_ready = ($urandom_range(0, 3) != 0);
            d_rsp_ready  = ($urandom_range(0, 3) != 0);
        end
        reset = 0;
        if_req_valid = 0; d_req_valid = 0;
        if_rsp_ready = 1; d_rsp_ready = 1;
        repeat (8) tick();
        chk("rand_if_activity", if_rsp_log.size() > 50, 1);
        chk("rand_d_activity", d_rsp_log.size() > 50, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port round-robin arbiter and sequencer in front of the single-port `SRAM` macro (7-bit word address, 32-bit data, 4-bit byte select). It shares the SRAM between an instruction-fetch port (read-only) and a data port (load/store with byte enables). Each accepted request becomes exactly one SRAM read or write with a fixed-latency response. It sits between the core's fetch/LSU units and the SRAM.

## Interface
Parameters:
- `ADDR_WIDTH`, default 7: SRAM word-address width.
- `DATA_WIDTH`, default 32: data width. Must be a multiple of 8. `BE_WIDTH = DATA_WIDTH/8`.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `if_req_valid`  in  1  fetch read request.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_req_addr`  in  ADDR_WIDTH  fetch word address.
- `if_rsp_valid`  out  1  fetch read data valid.
- `if_rsp_ready`  in  1  fetch consumer accepts response.
- `if_rsp_rdata`  out  DATA_WIDTH  fetch read data.
- `d_req_valid`  in  1  data request.
- `d_req_ready`  out  1  data request accepted this cycle.
- `d_req_we`  in  1  1 = write, 0 = read.
- `d_req_addr`  in  ADDR_WIDTH  data word address.
- `d_req_be`  in  BE_WIDTH  write byte enables (ignored for reads).
- `d_req_wdata`  in  DATA_WIDTH  write data.
- `d_rsp_valid`  out  1  data response (read data or write ack).
- `d_rsp_ready`  in  1  data consumer accepts response.
- `d_rsp_rdata`  out  DATA_WIDTH  read data; 0 for write acks.
- `sram_addr_sel`  out  ADDR_WIDTH  to SRAM `addr_sel`.
- `sram_byte_sel`  out  BE_WIDTH  to SRAM `byte_sel`.
- `sram_read_enable`  out  1  to SRAM `read_enable`.
- `sram_write_enable`  out  1  to SRAM `write_enable`.
- `sram_datain`  out  DATA_WIDTH  to SRAM `datain`.
- `sram_dataout`  in  DATA_WIDTH  from SRAM `dataout`. Valid in the cycle after the edge that samples `read_enable`.

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP. One request in flight at a time.
- **IDLE**
  - If any `*_req_valid` is high, select a winner and drive its `*_req_ready` high combinationally. The loser's ready stays low.
  - The handshake edge registers owner, we, addr, be, and wdata, updates `last_grant`, and moves the FSM to ACCESS.
- **Arbitration**
  - A single requester wins.
  - When both request, the winner is the port ≠ `last_grant`.
  - `last_grant` resets to 1 (data), so port 0 (fetch) wins the first tie.
- **ACCESS** (exactly 1 cycle)
  - Drive the registered address onto `sram_addr_sel`.
  - Read: `sram_read_enable`=1, `sram_byte_sel`=all-ones.
  - Write: `sram_write_enable`=1, `sram_byte_sel`=be, `sram_datain`=wdata.
  - Go to WAIT.
- **WAIT** (1 cycle)
  - SRAM enables are 0.
  - For reads, latch `sram_dataout` into the response register at the end of this cycle. For writes, load 0.
  - Go to RESP.
- **RESP**
  - Assert the owner's `*_rsp_valid`; rdata comes from the response register.
  - Hold valid and data stable until `*_rsp_ready`. On handshake, go to IDLE.
- Fetch requests are always reads.
- A data write with `be`=0 still performs the access cycle (no bytes change) and is acked.
- Outside ACCESS, SRAM control outputs are 0 and addr/byte_sel/datain are 0.
- Requesters must hold valid and payload stable until ready. Ready is never asserted outside IDLE.

## Timing
- Reset values: all `*_req_ready`, `*_rsp_valid`, and SRAM enables are 0. All data/address outputs are 0. FSM is IDLE and `last_grant`=1.
- Reset mid-operation: FSM returns to IDLE on the reset edge. The in-flight response is discarded; no `rsp_valid` is ever issued for it.
- Latency: accept edge T0 → ACCESS in cycle T0+1 → WAIT → `rsp_valid` high in the cycle after the third edge. A response held in RESP with `rsp_ready` high is 1 cycle.
- Minimum issue interval is 4 cycles per access: IDLE, ACCESS, WAIT, RESP.
- Back-pressure: while `rsp_ready` is low, the FSM stays in RESP and both req_ready stay 0.
- Requests arriving during a busy period wait in their valid state. Arbitration is evaluated only in IDLE.

## Test plan
- **Reset defaults:** assert reset 2 cycles → every output is 0. First accepted request after reset with both ports valid goes to fetch.
- **Data write then fetch read:** data write addr 10, wdata DEADBEEF, be 1111, then fetch read addr 10 → `if_rsp_rdata`=DEADBEEF. SRAM write_enable is high for exactly one cycle.
- **Byte-enable write:** write 12345678 with be 0011 to addr 10 holding DEADBEEF → data read returns DEAD5678. A write with be 0000 leaves DEAD5678 and is acked with rdata 0.
- **Round-robin fairness:** both ports continuously valid, fetch addr 5 (A5A5A5A5), data read addr 7 (5A5A5A5A) → grants alternate fetch, data, fetch, data. Each port receives its own correct data.
- **Response back-pressure:** hold `d_rsp_ready`=0 for 5 cycles during a data read with fetch pending → `d_rsp_valid` and `d_rsp_rdata` stay stable and `if_req_ready` stays 0. Fetch is granted in the IDLE cycle after the handshake.
- **Reset mid-access:** assert reset during WAIT of a fetch read → no `if_rsp_valid` appears. The next request completes normally with correct data.
